// File: rtl/host_cmd_pkg.sv
// Shared types and constants for the host command parser.
package host_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ARG,
        CSUM,
        HOLD
    } state_t;

    localparam logic [1:0] CLASS_HOST = 2'b00;
    localparam logic [1:0] CLASS_SD   = 2'b01;

    localparam logic [2:0] ERR_CSUM    = 3'd1;
    localparam logic [2:0] ERR_CLASS   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_FRAMING = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_SW_RESET  = 4'h1;
    localparam logic [3:0] OP_INIT_CARD = 4'h2;
    localparam logic [3:0] OP_READ_REGS = 4'h3;

    function automatic logic [1:0] cmd_class(input logic [7:0] cmd);
        return cmd[7:6];
    endfunction

endpackage

// File: rtl/host_cmd_timeout.sv
// Inter-byte timeout: clearable, enabled counter with terminal-count flag.
module host_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/host_cmd_parser.sv
// UART byte-stream framer/decoder feeding sd_fsm over valid/ready.
// Optional trailing XOR checksum byte: define HOST_CMD_CHECKSUM_EN.
module host_cmd_parser
    import host_cmd_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        ex_clk,
    input  logic        ex_resetn,
    input  logic [7:0]  uart_rx_data,
    input  logic [7:0]  uart_ctrl,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic        cmd_is_host,
    output logic [3:0]  host_cmd,
    output logic [5:0]  uart_cmd,
    output logic [31:0] cmd_arg,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic        busy
);

`ifdef HOST_CMD_CHECKSUM_EN
    localparam state_t FRAME_END = CSUM;
    logic [7:0] csum_acc;
`else
    localparam state_t FRAME_END = HOLD;
`endif

    state_t     state;
    logic [1:0] byte_cnt;
    logic       rx_stb;
    logic       frm_err;
    logic       partial;
    logic       tmo;
    logic       ctrl_unused;

    assign rx_stb      = uart_ctrl[0];
    assign frm_err     = uart_ctrl[1];
    assign ctrl_unused = ^uart_ctrl[7:2];
    assign partial     = (state == CMD) || (state == ARG) || (state == CSUM);

    host_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (ex_clk),
        .resetn(ex_resetn),
        .clr   (rx_stb || (state == IDLE)),
        .en    (partial),
        .tc    (tmo)
    );

    always_ff @(posedge ex_clk) begin
        if (!ex_resetn) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            cmd_valid   <= 1'b0;
            cmd_is_host <= 1'b0;
            host_cmd    <= 4'd0;
            uart_cmd    <= 6'd0;
            cmd_arg     <= 32'd0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            busy        <= 1'b0;
`ifdef HOST_CMD_CHECKSUM_EN
            csum_acc    <= 8'd0;
`endif
        end else begin
            err_valid <= 1'b0;
            // Framing beats strobe; strobe beats timeout.
            if (partial && frm_err) begin
                state     <= IDLE;
                busy      <= 1'b0;
                err_valid <= 1'b1;
                err_code  <= ERR_FRAMING;
            end else if (partial && !rx_stb && tmo) begin
                state     <= IDLE;
                busy      <= 1'b0;
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_stb && uart_rx_data == SYNC_BYTE) begin
                            state <= CMD;
                            busy  <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (rx_stb) begin
`ifdef HOST_CMD_CHECKSUM_EN
                            csum_acc <= uart_rx_data;
`endif
                            case (cmd_class(uart_rx_data))
                                CLASS_HOST: begin
                                    cmd_is_host <= 1'b1;
                                    host_cmd    <= uart_rx_data[3:0];
                                    state       <= FRAME_END;
                                    cmd_valid   <= (FRAME_END == HOLD);
                                end
                                CLASS_SD: begin
                                    cmd_is_host <= 1'b0;
                                    uart_cmd    <= uart_rx_data[5:0];
                                    byte_cnt    <= 2'd0;
                                    state       <= ARG;
                                end
                                default: begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_CLASS;
                                end
                            endcase
                        end
                    end
                    ARG: begin
                        if (rx_stb) begin
                            cmd_arg  <= {cmd_arg[23:0], uart_rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef HOST_CMD_CHECKSUM_EN
                            csum_acc <= csum_acc ^ uart_rx_data;
`endif
                            if (byte_cnt == 2'd3) begin
                                state     <= FRAME_END;
                                cmd_valid <= (FRAME_END == HOLD);
                            end
                        end
                    end
`ifdef HOST_CMD_CHECKSUM_EN
                    CSUM: begin
                        if (rx_stb) begin
                            if (uart_rx_data == csum_acc) begin
                                state     <= HOLD;
                                cmd_valid <= 1'b1;
                            end else begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                err_valid <= 1'b1;
                                err_code  <= ERR_CSUM;
                            end
                        end
                    end
`endif
                    HOLD: begin
                        if (rx_stb) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_OVERRUN;
                        end
                        if (cmd_ready) begin
                            state     <= IDLE;
                            cmd_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Randomised self-checking bench for host_cmd_parser.
module tb_host_cmd_parser;

    localparam int TO = 16;

    logic        ex_clk = 1'b0;
    logic        ex_resetn = 1'b0;
    logic [7:0]  uart_rx_data = 8'd0;
    logic [7:0]  uart_ctrl = 8'd0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic        cmd_is_host;
    logic [3:0]  host_cmd;
    logic [5:0]  uart_cmd;
    logic [31:0] cmd_arg;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        busy;

    host_cmd_parser #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .ex_clk      (ex_clk),
        .ex_resetn   (ex_resetn),
        .uart_rx_data(uart_rx_data),
        .uart_ctrl   (uart_ctrl),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_is_host (cmd_is_host),
        .host_cmd    (host_cmd),
        .uart_cmd    (uart_cmd),
        .cmd_arg     (cmd_arg),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 ex_clk = ~ex_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    int e0;

    // Only the fields meaningful for the presented class are compared.
    logic [42:0] dec_view;
    assign dec_view = cmd_is_host ? {1'b1, host_cmd, 38'd0}
                                  : {1'b0, 4'd0, uart_cmd, cmd_arg};

    logic [42:0] e_dec;
    logic [7:0]  frame[$];

    always @(negedge ex_clk) begin
        if (err_valid) n_err++;
    end

    task automatic tick();
        @(posedge ex_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_data = b;
        uart_ctrl    = {6'($urandom), 2'b01};
        tick();
        uart_ctrl    = 8'd0;
    endtask

    task automatic make_frame(input logic [7:0] c, input logic [31:0] arg);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(c);
        x = c;
        if (c[7:6] == 2'b00) begin
            e_dec = {1'b1, c[3:0], 38'd0};
        end else begin
            e_dec = {1'b0, 4'd0, c[5:0], arg};
            for (int i = 3; i >= 0; i--) begin
                frame.push_back(arg[8*i +: 8]);
                x = x ^ arg[8*i +: 8];
            end
        end
`ifdef HOST_CMD_CHECKSUM_EN
        frame.push_back(x);
`endif
    endtask

    task automatic rand_frame(input bit host);
        logic [7:0] c;
        c = host ? {2'b00, 6'($urandom)} : {2'b01, 6'($urandom)};
        make_frame(c, $urandom);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame[i]) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_byte(frame[i]);
        end
    endtask

    task automatic test_reset();
        ex_resetn = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({cmd_valid, err_valid, busy, cmd_is_host} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {cmd_valid, err_valid, busy, cmd_is_host});
        end
        n_cmp++;
        if ({host_cmd, uart_cmd, err_code} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_codes: got %h want 0",
                     {host_cmd, uart_cmd, err_code});
        end
        n_cmp++;
        if (cmd_arg !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_arg: got %h want 0", cmd_arg);
        end
        ex_resetn = 1'b1;
        tick();
    endtask

    task automatic test_host_cmd();
        cmd_ready = 1'b1;
        e0 = n_err;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) make_frame(8'h02, 32'd0);
            else rand_frame(1'b1);
            send_frame(3);
            n_cmp++;
            if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
                n_bad++;
                $display("FAIL host_present: got %b/%h want 1/%h",
                         cmd_valid, dec_view, e_dec);
            end
            tick();
            n_cmp++;
            if ({cmd_valid, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL host_handshake: got %b want 00",
                         {cmd_valid, busy});
            end
        end
        n_cmp++;
        if (n_err !== e0) begin
            n_bad++;
            $display("FAIL host_no_err: got %0d want %0d", n_err, e0);
        end
    endtask

    task automatic test_sd_backpressure();
        int hold;
        cmd_ready = 1'b0;
        e0 = n_err;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) make_frame(8'h51, 32'h0000_0200);
            else rand_frame(1'b0);
            hold = (k == 0) ? 10 : $urandom_range(1, 6);
            send_frame(2);
            for (int c = 0; c < hold; c++) begin
                n_cmp++;
                if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
                    n_bad++;
                    $display("FAIL sd_hold c%0d: got %b/%h want 1/%h",
                             c, cmd_valid, dec_view, e_dec);
                end
                tick();
            end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            n_cmp++;
            if ({cmd_valid, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL sd_release: got %b want 00", {cmd_valid, busy});
            end
        end
        n_cmp++;
        if (n_err !== e0) begin
            n_bad++;
            $display("FAIL sd_no_err: got %0d want %0d", n_err, e0);
        end
    endtask

`ifdef HOST_CMD_CHECKSUM_EN
    task automatic test_bad_csum();
        cmd_ready = 1'b1;
        e0 = n_err;
        frame = '{8'hA5, 8'h01, 8'hFF};
        send_frame(0);
        n_cmp++;
        if ({err_valid, err_code, cmd_valid} !== {1'b1, 3'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL csum_err: got %b want 10010",
                     {err_valid, err_code, cmd_valid});
        end
        tick();
        n_cmp++;
        if ({err_valid, cmd_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL csum_pulse: got %b want 000",
                     {err_valid, cmd_valid, busy});
        end
        rand_frame($urandom_range(0, 1) == 1);
        send_frame(1);
        n_cmp++;
        if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
            n_bad++;
            $display("FAIL csum_recover: got %b/%h want 1/%h",
                     cmd_valid, dec_view, e_dec);
        end
        tick();
        n_cmp++;
        if (n_err !== e0 + 1) begin
            n_bad++;
            $display("FAIL csum_err_cnt: got %0d want %0d", n_err, e0 + 1);
        end
    endtask
`endif

    task automatic test_timeout();
        cmd_ready = 1'b1;
        make_frame(8'h41, $urandom);
        send_byte(frame[0]);
        send_byte(frame[1]);
        repeat (TO - 1) tick();
        n_cmp++;
        if ({busy, err_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL tmo_early: got %b want 10", {busy, err_valid});
        end
        tick();
        n_cmp++;
        if ({err_valid, err_code, busy} !== {1'b1, 3'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_fire: got %b want 10110",
                     {err_valid, err_code, busy});
        end
        tick();
        e0 = n_err;
        make_frame(8'h41, $urandom);
        send_byte(frame[0]);
        send_byte(frame[1]);
        repeat (TO - 1) tick();
        for (int i = 2; i < frame.size(); i++) send_byte(frame[i]);
        n_cmp++;
        if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
            n_bad++;
            $display("FAIL tmo_edge_strobe: got %b/%h want 1/%h",
                     cmd_valid, dec_view, e_dec);
        end
        tick();
        n_cmp++;
        if (n_err !== e0) begin
            n_bad++;
            $display("FAIL tmo_edge_err: got %0d want %0d", n_err, e0);
        end
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        rand_frame(1'b0);
        send_frame(1);
        send_byte(8'($urandom));
        n_cmp++;
        if ({err_valid, err_code} !== {1'b1, 3'd5}) begin
            n_bad++;
            $display("FAIL overrun_err: got %b want 1101",
                     {err_valid, err_code});
        end
        n_cmp++;
        if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
            n_bad++;
            $display("FAIL overrun_hold: got %b/%h want 1/%h",
                     cmd_valid, dec_view, e_dec);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++;
        if ({cmd_valid, err_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL overrun_release: got %b want 000",
                     {cmd_valid, err_valid, busy});
        end
    endtask

    task automatic test_framing();
        cmd_ready = 1'b1;
        uart_ctrl = 8'h02;
        tick();
        uart_ctrl = 8'h00;
        n_cmp++;
        if ({err_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL framing_idle: got %b want 00", {err_valid, busy});
        end
        rand_frame(1'b0);
        for (int i = 0; i < 3; i++) send_byte(frame[i]);
        uart_rx_data = 8'($urandom);
        uart_ctrl = {7'd1, 1'($urandom)};
        tick();
        uart_ctrl = 8'h00;
        n_cmp++;
        if ({err_valid, err_code, busy} !== {1'b1, 3'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL framing_arg: got %b want 11000",
                     {err_valid, err_code, busy});
        end
        tick();
    endtask

    task automatic test_bad_class();
        send_byte(8'hA5);
        send_byte({1'b1, 7'($urandom)});
        n_cmp++;
        if ({err_valid, err_code, busy, cmd_valid} !== {1'b1, 3'd2, 2'b00}) begin
            n_bad++;
            $display("FAIL bad_class: got %b want 101000",
                     {err_valid, err_code, busy, cmd_valid});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        e0 = n_err;
        make_frame(8'h51, $urandom);
        for (int i = 0; i < 3; i++) send_byte(frame[i]);
        ex_resetn = 1'b0;
        tick();
        n_cmp++;
        if ({cmd_valid, err_valid, busy, cmd_is_host, host_cmd, uart_cmd,
             cmd_arg, err_code} !== 49'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h want 0",
                     {cmd_valid, err_valid, busy, cmd_is_host, host_cmd,
                      uart_cmd, cmd_arg, err_code});
        end
        tick();
        ex_resetn = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (n_err !== e0) begin
            n_bad++;
            $display("FAIL reset_mid_err: got %0d want %0d", n_err, e0);
        end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        e0 = n_err;
        for (int k = 0; k < 6; k++) begin
            rand_frame($urandom_range(0, 1) == 1);
            send_frame(0);
            n_cmp++;
            if ({cmd_valid, dec_view} !== {1'b1, e_dec}) begin
                n_bad++;
                $display("FAIL b2b_%0d: got %b/%h want 1/%h",
                         k, cmd_valid, dec_view, e_dec);
            end
            tick();
        end
        n_cmp++;
        if ({n_err, cmd_valid} !== {e0, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_tail: got %0d/%b want %0d/0",
                     n_err, cmd_valid, e0);
        end
    endtask

    initial begin
        test_reset();
        test_host_cmd();
        test_sd_backpressure();
`ifdef HOST_CMD_CHECKSUM_EN
        test_bad_csum();
`endif
        test_timeout();
        test_overrun();
        test_framing();
        test_bad_class();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
